pix_clk_coord: RTL and testbench
================================

# pix_clk_coord

Timing and addressing helper for the 96×64 OLED pipeline. It combines a programmable clock divider with a pixel-index-to-coordinate converter. The divider produces the slow enable-style clocks used by the display and UI logic, for example 6.25 MHz from 100 MHz for the OLED driver and 200 Hz for seven-segment scanning and timers. The converter turns the OLED driver's linear `pix_index` into `x`/`y` for the drawing logic.

## Interface
- `WIDTH`, default 96: pixels per row; the divisor for the index conversion.
- `HEIGHT`, default 64: rows per frame; documents the valid index range `0..WIDTH*HEIGHT-1`.
- `basys_clk`, in, 1: system clock (100 MHz on board).
- `reset_n`, in, 1: asynchronous, active-low reset.
- `count_in`, in, 32: divider terminal count; half-period of `out_clk` is `count_in+1` clocks.
- `out_clk`, out, 1: divided clock, 50 % duty.
- `tick`, out, 1: one-cycle pulse on every `out_clk` toggle. Present only with `DIV_TICK_EN`.
- `pix_index`, in, 13: linear pixel index from the OLED driver, row-major.
- `x`, out, 13: column, `pix_index % WIDTH`.
- `y`, out, 13: row, `pix_index / WIDTH`.

## Operation
- Divider state is a 32-bit counter `cnt` plus the `out_clk` register. On each `basys_clk` rising edge:
  - If `cnt >= count_in`: set `cnt` to 0 and invert `out_clk`.
  - Otherwise: increment `cnt` by 1.
- Output frequency is f_clk / (2·(count_in+1)).
  - `count_in=7` gives 6.25 MHz.
  - `count_in=249_999` gives 200 Hz.
  - `count_in=0` gives f_clk/2, toggling every cycle.
- `count_in` may change at any time. Because the comparison is `>=`, lowering `count_in` below the current `cnt` causes a toggle on the next edge, with no 2^32 wrap.
- Coordinate conversion is purely combinational: `x = pix_index % WIDTH` and `y = pix_index / WIDTH`, zero-extended to 13 bits.
- Indices `>= WIDTH*HEIGHT` are not clamped. Arithmetic still applies; for example, 8191 gives x=31, y=85.
- Converter holds no state and is unaffected by reset.

## Timing
- Reset asserted (`reset_n=0`): `cnt=0`, `out_clk=0`, and `tick=0` immediately, independent of the clock.
- Reset release: the first `out_clk` rising edge occurs on the (count_in+1)-th `basys_clk` rising edge after release.
- Reset asserted mid-count: `out_clk` goes to 0 immediately. The count restarts from 0 after release.
- `tick` (when enabled) is registered. It is high for exactly the one cycle following the edge on which `out_clk` changed, so it is aligned with the new `out_clk` value.
  - With `count_in=0`, `tick` is high continuously.
- `x`/`y` have zero-cycle latency and are valid within the same cycle as `pix_index`.
- `out_clk` is a fabric-generated clock. Consumers needing tight timing should use `tick` as a clock enable instead.

## Configuration
- Macro `DIV_TICK_EN`.
- Defined: the `tick` port and its register exist, behaving as described under Timing.
- Undefined: no `tick` port and no tick register. All other behaviour is identical.

## Test plan
- Frequency check: reset, release, hold `count_in=7`.
  - `out_clk` first rises at cycle 8, then has a period of 16 cycles with 8 high and 8 low.
  - With `DIV_TICK_EN`, `tick` pulses every 8 cycles.
- Minimum divisor: `count_in=0` makes `out_clk` toggle every cycle (period 2). `count_in=3` gives a period of 8.
- Shrinking the divisor: run with `count_in=100`. At `cnt=50`, change `count_in` to 10.
  - `out_clk` toggles on the next edge.
  - It then toggles every 11 cycles.
- Reset mid-count: assert `reset_n=0` while `out_clk=1` and `cnt=5`.
  - `out_clk=0` without waiting for a clock edge.
  - After release, the first rise is at cycle `count_in+1`.
- Coordinate mapping:
  - 0 → (0,0)
  - 95 → (95,0)
  - 96 → (0,1)
  - 3071 → (95,31)
  - 6143 → (95,63)
  - 8191 → (31,85)
  - Outputs settle combinationally.
- Sweep: all `pix_index` values 0..6143 satisfy `x + 96·y == pix_index` with `x<96` and `y<64`.

Source files
------------

// File: rtl/pix_clk_coord_if.sv
// Divider control/output and pixel coordinate bundle for pix_clk_coord.
// Optional tick member exists only when DIV_TICK_EN is defined.
interface pix_clk_coord_if;
    logic [31:0] count_in;
    logic        out_clk;
`ifdef DIV_TICK_EN
    logic        tick;
`endif
    logic [12:0] pix_index;
    logic [12:0] x;
    logic [12:0] y;

    modport master (
`ifdef DIV_TICK_EN
        input  tick,
`endif
        output count_in,
        output pix_index,
        input  out_clk,
        input  x,
        input  y
    );

    modport slave (
`ifdef DIV_TICK_EN
        output tick,
`endif
        input  count_in,
        input  pix_index,
        output out_clk,
        output x,
        output y
    );
endinterface

// File: rtl/pix_clk_coord.sv
// Programmable 50% clock divider plus linear pixel index to x/y converter.
// Define DIV_TICK_EN to add a registered one-cycle tick on every out_clk toggle.
module pix_clk_coord #(
    parameter int unsigned WIDTH  = 96,
    parameter int unsigned HEIGHT = 64
) (
    input  logic            basys_clk,
    input  logic            reset_n,
    pix_clk_coord_if.slave  bus
);
    localparam logic [12:0] W13 = 13'(WIDTH);

    // The index port is 13 bits wide, so a larger frame cannot be addressed.
    if (WIDTH * HEIGHT > 8192) begin : g_bad_geometry
        $error("pix_clk_coord: WIDTH*HEIGHT exceeds 13-bit index range");
    end

    logic [31:0] cnt;
    logic        wrap;

    // >= rather than == so lowering count_in mid-count never waits for a 2^32 wrap.
    assign wrap = (cnt >= bus.count_in);

    always_ff @(posedge basys_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            bus.out_clk <= 1'b0;
        end else if (wrap) begin
            cnt         <= '0;
            bus.out_clk <= ~bus.out_clk;
        end else begin
            cnt         <= cnt + 32'd1;
        end
    end

`ifdef DIV_TICK_EN
    always_ff @(posedge basys_clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.tick <= 1'b0;
        end else begin
            bus.tick <= wrap;
        end
    end
`endif

    assign bus.x = bus.pix_index % W13;
    assign bus.y = bus.pix_index / W13;

endmodule

// File: tb/tb_pix_clk_coord.sv
// Directed bench for pix_clk_coord: divider timing, reset, count change, coordinates.
// Tick checks are compiled in only when DIV_TICK_EN is defined.
module tb_pix_clk_coord;
    logic basys_clk;
    logic reset_n;
    int   nvec;
    int   nerr;

    pix_clk_coord_if bus ();

    pix_clk_coord #(
        .WIDTH  (96),
        .HEIGHT (64)
    ) dut (
        .basys_clk (basys_clk),
        .reset_n   (reset_n),
        .bus       (bus.slave)
    );

    initial basys_clk = 1'b0;
    always #5 basys_clk = ~basys_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge basys_clk);
        @(negedge basys_clk);
    endtask

    task automatic do_reset(input logic [31:0] ci);
        reset_n      = 1'b0;
        bus.count_in = ci;
        step(2);
        reset_n      = 1'b1;
    endtask

    initial begin
        int ex;
        int ey;
        nvec          = 0;
        nerr          = 0;
        reset_n       = 1'b0;
        bus.count_in  = 32'd7;
        bus.pix_index = 13'd0;
        #1;
        chk("rst_out_clk", {31'd0, bus.out_clk}, 32'd0);
`ifdef DIV_TICK_EN
        chk("rst_tick", {31'd0, bus.tick}, 32'd0);
`endif

        // count_in = 7: first rise on edge 8, then 8 high / 8 low
        do_reset(32'd7);
        step(7);
        chk("c7_e7", {31'd0, bus.out_clk}, 32'd0);
        step(1);
        chk("c7_e8", {31'd0, bus.out_clk}, 32'd1);
`ifdef DIV_TICK_EN
        chk("c7_tick_e8", {31'd0, bus.tick}, 32'd1);
        step(1);
        chk("c7_tick_e9", {31'd0, bus.tick}, 32'd0);
        step(6);
`else
        step(7);
`endif
        chk("c7_e15", {31'd0, bus.out_clk}, 32'd1);
        step(1);
        chk("c7_e16", {31'd0, bus.out_clk}, 32'd0);
`ifdef DIV_TICK_EN
        chk("c7_tick_e16", {31'd0, bus.tick}, 32'd1);
`endif
        step(7);
        chk("c7_e23", {31'd0, bus.out_clk}, 32'd0);
        step(1);
        chk("c7_e24", {31'd0, bus.out_clk}, 32'd1);

        // count_in = 0 from cnt = 0: toggle on every edge
        bus.count_in = 32'd0;
        step(1);
        chk("c0_t1", {31'd0, bus.out_clk}, 32'd0);
        step(1);
        chk("c0_t2", {31'd0, bus.out_clk}, 32'd1);
        step(1);
        chk("c0_t3", {31'd0, bus.out_clk}, 32'd0);
`ifdef DIV_TICK_EN
        chk("c0_tick", {31'd0, bus.tick}, 32'd1);
`endif

        // count_in = 3: period 8
        do_reset(32'd3);
        step(3);
        chk("c3_e3", {31'd0, bus.out_clk}, 32'd0);
        step(1);
        chk("c3_e4", {31'd0, bus.out_clk}, 32'd1);
        step(3);
        chk("c3_e7", {31'd0, bus.out_clk}, 32'd1);
        step(1);
        chk("c3_e8", {31'd0, bus.out_clk}, 32'd0);
        step(4);
        chk("c3_e12", {31'd0, bus.out_clk}, 32'd1);

        // shrink 100 -> 10 at cnt = 50
        do_reset(32'd100);
        step(50);
        chk("shr_pre", {31'd0, bus.out_clk}, 32'd0);
        bus.count_in = 32'd10;
        step(1);
        chk("shr_next", {31'd0, bus.out_clk}, 32'd1);
        step(10);
        chk("shr_p10", {31'd0, bus.out_clk}, 32'd1);
        step(1);
        chk("shr_p11", {31'd0, bus.out_clk}, 32'd0);
        step(10);
        chk("shr_p21", {31'd0, bus.out_clk}, 32'd0);
        step(1);
        chk("shr_p22", {31'd0, bus.out_clk}, 32'd1);

        // async reset with out_clk = 1, cnt = 5
        do_reset(32'd7);
        step(13);
        chk("mid_pre", {31'd0, bus.out_clk}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_async", {31'd0, bus.out_clk}, 32'd0);
`ifdef DIV_TICK_EN
        chk("mid_tick", {31'd0, bus.tick}, 32'd0);
`endif
        step(1);
        reset_n = 1'b1;
        step(7);
        chk("mid_e7", {31'd0, bus.out_clk}, 32'd0);
        step(1);
        chk("mid_e8", {31'd0, bus.out_clk}, 32'd1);

        // directed coordinates
        bus.pix_index = 13'd0;    #1;
        chk("pix0_x", {19'd0, bus.x}, 32'd0);
        chk("pix0_y", {19'd0, bus.y}, 32'd0);
        bus.pix_index = 13'd95;   #1;
        chk("pix95_x", {19'd0, bus.x}, 32'd95);
        chk("pix95_y", {19'd0, bus.y}, 32'd0);
        bus.pix_index = 13'd96;   #1;
        chk("pix96_x", {19'd0, bus.x}, 32'd0);
        chk("pix96_y", {19'd0, bus.y}, 32'd1);
        bus.pix_index = 13'd3071; #1;
        chk("pix3071_x", {19'd0, bus.x}, 32'd95);
        chk("pix3071_y", {19'd0, bus.y}, 32'd31);
        bus.pix_index = 13'd6143; #1;
        chk("pix6143_x", {19'd0, bus.x}, 32'd95);
        chk("pix6143_y", {19'd0, bus.y}, 32'd63);
        bus.pix_index = 13'd8191; #1;
        chk("pix8191_x", {19'd0, bus.x}, 32'd31);
        chk("pix8191_y", {19'd0, bus.y}, 32'd85);

        // raster-scan sweep using a running column/row counter model
        ex = 0;
        ey = 0;
        for (int i = 0; i < 6144; i++) begin
            bus.pix_index = 13'(i);
            #1;
            chk("sweep_xy", {6'd0, bus.y, bus.x},
                {6'd0, 13'(ey), 13'(ex)});
            ex++;
            if (ex == 96) begin
                ex = 0;
                ey++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
